// File: rtl/receptor_bus16.sv
// Read-side endpoint of the shared tri-state bus: qualifies enabled bus words by
// stability, queues them in a first-word-fall-through FIFO, and hands them out via valid/ready.
module receptor_bus16 #(
   parameter int ANCHO   = 16,
   parameter int PROF    = 4,
   parameter int ESTABLE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ANCHO-1:0]        Bus,
   input  logic                    Habilitador,
   output logic [ANCHO-1:0]        Dato,
   output logic                    Valido,
   input  logic                    Listo,
   output logic                    Lleno,
   output logic                    Vacio,
   output logic [$clog2(PROF):0]   Cuenta,
   output logic                    Desborde
);

   localparam int PW = $clog2(PROF);
   localparam int CW = PW + 1;
   localparam int NW = 4;

   typedef enum logic [1:0] {
      INACTIVO,
      ESTABILIZANDO,
      CAPTURADO
   } estado_t;

   estado_t            r_estado;
   estado_t            w_estado_sig;
   logic [ANCHO-1:0]   r_ref;
   logic [ANCHO-1:0]   w_ref_sig;
   logic [NW-1:0]      r_cnt;
   logic [NW-1:0]      w_cnt_sig;
   logic [NW-1:0]      w_cnt_inc;
   logic               w_push;

   logic [ANCHO-1:0]   r_mem [PROF];
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_cuenta;
   logic               r_desborde;
   logic               w_pop;
   logic               w_lleno;
   logic               w_vacio;
   logic               w_wr_ok;

   // ---------------- capture FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado <= INACTIVO;
         r_ref    <= '0;
         r_cnt    <= '0;
      end else begin
         r_estado <= w_estado_sig;
         r_ref    <= w_ref_sig;
         r_cnt    <= w_cnt_sig;
      end
   end

   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_estado_sig = r_estado;
      w_ref_sig    = r_ref;
      w_cnt_sig    = r_cnt;
      w_push       = 1'b0;
      case (r_estado)
         INACTIVO: begin
            if (Habilitador) begin
               w_ref_sig    = Bus;
               w_cnt_sig    = NW'(1);
               w_estado_sig = ESTABILIZANDO;
            end
         end
         ESTABILIZANDO: begin
            if (!Habilitador) begin
               w_estado_sig = INACTIVO;
            end else if (Bus != r_ref) begin
               w_ref_sig = Bus;
               w_cnt_sig = NW'(1);
            end else begin
               w_cnt_sig = w_cnt_inc;
               if (w_cnt_inc == NW'(ESTABLE)) begin
                  w_push       = 1'b1;
                  w_estado_sig = CAPTURADO;
               end
            end
         end
         CAPTURADO: begin
            if (!Habilitador) begin
               w_estado_sig = INACTIVO;
            end else if (Bus != r_ref) begin
               w_ref_sig    = Bus;
               w_cnt_sig    = NW'(1);
               w_estado_sig = ESTABILIZANDO;
            end
         end
         default: begin
            w_estado_sig = INACTIVO;
         end
      endcase
   end

   // ---------------- FIFO ----------------
   assign w_vacio = (r_cuenta == '0);
   assign w_lleno = (r_cuenta == CW'(PROF));
   assign w_pop   = !w_vacio && Listo;
   // A full FIFO still takes a word when the same edge pops the head.
   assign w_wr_ok = w_push && (!w_lleno || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < PROF; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= r_ref;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cuenta   <= '0;
         r_desborde <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_ok, w_pop})
            2'b10:   r_cuenta <= r_cuenta + 1'b1;
            2'b01:   r_cuenta <= r_cuenta - 1'b1;
            default: r_cuenta <= r_cuenta;
         endcase
         if (w_push && !w_wr_ok) begin
            r_desborde <= 1'b1;
         end
      end
   end

   assign Dato     = r_mem[r_rd_ptr];
   assign Valido   = !w_vacio;
   assign Vacio    = w_vacio;
   assign Lleno    = w_lleno;
   assign Cuenta   = r_cuenta;
   assign Desborde = r_desborde;

endmodule

// File: tb/tb_receptor_bus16.sv
// Bench for receptor_bus16: directed scenarios plus randomized traffic checked
// against a run-length / queue reference model.
module tb_receptor_bus16;

   localparam int ANCHO   = 16;
   localparam int PROF    = 4;
   localparam int ESTABLE = 2;

   logic              clk;
   logic              rst_n;
   logic [ANCHO-1:0]  Bus;
   logic              Habilitador;
   logic [ANCHO-1:0]  Dato;
   logic              Valido;
   logic              Listo;
   logic              Lleno;
   logic              Vacio;
   logic [2:0]        Cuenta;
   logic              Desborde;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: FIFO contents, current run of identical enabled samples, sticky overflow
   logic [ANCHO-1:0]  m_q[$];
   int                m_run;
   logic [ANCHO-1:0]  m_last;
   logic              m_ovf;

   receptor_bus16 #(.ANCHO(ANCHO), .PROF(PROF), .ESTABLE(ESTABLE)) dut (
      .clk(clk), .rst_n(rst_n), .Bus(Bus), .Habilitador(Habilitador),
      .Dato(Dato), .Valido(Valido), .Listo(Listo), .Lleno(Lleno),
      .Vacio(Vacio), .Cuenta(Cuenta), .Desborde(Desborde)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   task automatic model_clear();
      m_q.delete();
      m_run  = 0;
      m_last = '0;
      m_ovf  = 1'b0;
   endtask

   // drive one cycle, advance the model at the edge, land 1 time unit after it
   task automatic step(input logic h, input logic [ANCHO-1:0] b, input logic l);
      bit pop, push;
      logic [ANCHO-1:0] dummy;
      Habilitador = h; Bus = b; Listo = l;
      @(posedge clk);
      pop = (m_q.size() > 0) && l;
      if (h) begin
         if (m_run > 0 && b == m_last) m_run++;
         else begin m_run = 1; m_last = b; end
      end else begin
         m_run = 0;
      end
      push = (m_run == ESTABLE);
      if (push && m_q.size() == PROF && !pop) begin
         m_ovf = 1'b1;
      end else begin
         if (pop) dummy = m_q.pop_front();
         if (push) m_q.push_back(b);
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; Habilitador = 1'b0; Listo = 1'b0; Bus = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; Bus = 16'hFFFF; Habilitador = 1'b1; Listo = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (Dato !== 16'h0000) $display("FAIL reset_dato got=%h exp=0000", Dato); else n_pass++;
      n_checks++; if (Valido !== 1'b0) $display("FAIL reset_valido got=%b exp=0", Valido); else n_pass++;
      n_checks++; if (Vacio !== 1'b1) $display("FAIL reset_vacio got=%b exp=1", Vacio); else n_pass++;
      n_checks++; if (Lleno !== 1'b0) $display("FAIL reset_lleno got=%b exp=0", Lleno); else n_pass++;
      n_checks++; if (Cuenta !== 3'd0) $display("FAIL reset_cuenta got=%0d exp=0", Cuenta); else n_pass++;
      n_checks++; if (Desborde !== 1'b0) $display("FAIL reset_desborde got=%b exp=0", Desborde); else n_pass++;
      #1 rst_n = 1'b1;
      model_clear();
      step(1'b1, 16'hFFFF, 1'b0);
      n_checks++; if (Valido !== 1'b0) $display("FAIL reset_first_sample_valido got=%b exp=0", Valido); else n_pass++;
      step(1'b1, 16'hFFFF, 1'b0);
      n_checks++; if (Valido !== 1'b1) $display("FAIL reset_push_valido got=%b exp=1", Valido); else n_pass++;
      n_checks++; if (Dato !== 16'hFFFF) $display("FAIL reset_push_dato got=%h exp=ffff", Dato); else n_pass++;
      n_checks++; if (Cuenta !== 3'd1) $display("FAIL reset_push_cuenta got=%0d exp=1", Cuenta); else n_pass++;
   endtask

   task automatic test_glitch();
      logic [15:0] v;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         v = 16'(i);
         step(~v[0], v, 1'b0);
         n_checks++; if (Vacio !== 1'b1) $display("FAIL glitch_vacio cyc=%0d got=%b exp=1", i, Vacio); else n_pass++;
      end
   endtask

   task automatic test_stable_sequence();
      logic [ANCHO-1:0] got[$];
      logic [ANCHO-1:0] seq[9] = '{16'h1234, 16'h1234, 16'h1234, 16'h5678, 16'h5678, 16'h5678, 0, 0, 0};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (Valido) got.push_back(Dato);
         step(i < 6, seq[i], 1'b1);
         n_checks++; if (Cuenta !== 3'(m_q.size())) $display("FAIL seq_cuenta cyc=%0d got=%0d exp=%0d", i, Cuenta, m_q.size()); else n_pass++;
      end
      n_checks++; if (got.size() != 2) $display("FAIL seq_count got=%0d exp=2", got.size()); else n_pass++;
      if (got.size() == 2) begin
         n_checks++; if (got[0] !== 16'h1234) $display("FAIL seq_word0 got=%h exp=1234", got[0]); else n_pass++;
         n_checks++; if (got[1] !== 16'h5678) $display("FAIL seq_word1 got=%h exp=5678", got[1]); else n_pass++;
      end
   endtask

   task automatic test_overflow();
      logic [ANCHO-1:0] got[$];
      do_reset();
      for (int w = 1; w <= 5; w++) begin
         step(1'b1, 16'(w), 1'b0);
         step(1'b1, 16'(w), 1'b0);
      end
      n_checks++; if (Lleno !== 1'b1) $display("FAIL ovf_lleno got=%b exp=1", Lleno); else n_pass++;
      n_checks++; if (Cuenta !== 3'd4) $display("FAIL ovf_cuenta got=%0d exp=4", Cuenta); else n_pass++;
      n_checks++; if (Desborde !== 1'b1) $display("FAIL ovf_desborde got=%b exp=1", Desborde); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         if (Valido) got.push_back(Dato);
         step(1'b0, 16'h0000, 1'b1);
      end
      n_checks++; if (got.size() != 4) $display("FAIL ovf_drain_count got=%0d exp=4", got.size()); else n_pass++;
      for (int i = 0; i < got.size() && i < 4; i++) begin
         n_checks++; if (got[i] !== 16'(i + 1)) $display("FAIL ovf_drain_word%0d got=%h exp=%h", i, got[i], 16'(i + 1)); else n_pass++;
      end
      n_checks++; if (Desborde !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", Desborde); else n_pass++;
   endtask

   task automatic test_push_pop_full();
      logic [ANCHO-1:0] got[$];
      logic [ANCHO-1:0] exp[5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'hAAAA};
      do_reset();
      for (int w = 0; w < 4; w++) begin
         step(1'b1, exp[w], 1'b0);
         step(1'b1, exp[w], 1'b0);
      end
      step(1'b1, 16'hAAAA, 1'b0);
      if (Valido) got.push_back(Dato);
      step(1'b1, 16'hAAAA, 1'b1);
      n_checks++; if (Cuenta !== 3'd4) $display("FAIL pp_cuenta got=%0d exp=4", Cuenta); else n_pass++;
      n_checks++; if (Lleno !== 1'b1) $display("FAIL pp_lleno got=%b exp=1", Lleno); else n_pass++;
      n_checks++; if (Desborde !== 1'b0) $display("FAIL pp_desborde got=%b exp=0", Desborde); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         if (Valido) got.push_back(Dato);
         step(1'b0, 16'h0000, 1'b1);
      end
      n_checks++; if (got.size() != 5) $display("FAIL pp_drain_count got=%0d exp=5", got.size()); else n_pass++;
      for (int i = 0; i < got.size() && i < 5; i++) begin
         n_checks++; if (got[i] !== exp[i]) $display("FAIL pp_drain_word%0d got=%h exp=%h", i, got[i], exp[i]); else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [ANCHO-1:0] pool[3];
      logic [ANCHO-1:0] b;
      logic h, l;
      do_reset();
      for (int k = 0; k < 3; k++) pool[k] = 16'($urandom);
      b = pool[0];
      for (int i = 0; i < 400; i++) begin
         h = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 9) < 3) b = pool[$urandom_range(0, 2)];
         l = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step(h, b, l);
         n_checks++; if (Cuenta !== 3'(m_q.size())) $display("FAIL rand_cuenta cyc=%0d got=%0d exp=%0d", i, Cuenta, m_q.size()); else n_pass++;
         n_checks++; if (Valido !== (m_q.size() != 0)) $display("FAIL rand_valido cyc=%0d got=%b exp=%b", i, Valido, m_q.size() != 0); else n_pass++;
         n_checks++; if (Vacio !== (m_q.size() == 0)) $display("FAIL rand_vacio cyc=%0d got=%b exp=%b", i, Vacio, m_q.size() == 0); else n_pass++;
         n_checks++; if (Lleno !== (m_q.size() == PROF)) $display("FAIL rand_lleno cyc=%0d got=%b exp=%b", i, Lleno, m_q.size() == PROF); else n_pass++;
         n_checks++; if (Desborde !== m_ovf) $display("FAIL rand_desborde cyc=%0d got=%b exp=%b", i, Desborde, m_ovf); else n_pass++;
         if (m_q.size() > 0) begin
            n_checks++; if (Dato !== m_q[0]) $display("FAIL rand_dato cyc=%0d got=%h exp=%h", i, Dato, m_q[0]); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_qual();
      do_reset();
      for (int w = 1; w <= 2; w++) begin
         step(1'b1, 16'(w * 3), 1'b0);
         step(1'b1, 16'(w * 3), 1'b0);
      end
      step(1'b1, 16'hBEEF, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (Cuenta !== 3'd0) $display("FAIL midrst_cuenta got=%0d exp=0", Cuenta); else n_pass++;
      n_checks++; if (Valido !== 1'b0) $display("FAIL midrst_valido got=%b exp=0", Valido); else n_pass++;
      n_checks++; if (Vacio !== 1'b1) $display("FAIL midrst_vacio got=%b exp=1", Vacio); else n_pass++;
      n_checks++; if (Dato !== 16'h0000) $display("FAIL midrst_dato got=%h exp=0000", Dato); else n_pass++;
      Habilitador = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 16'hBEEF, 1'b0);
         n_checks++; if (Vacio !== 1'b1) $display("FAIL midrst_after_vacio cyc=%0d got=%b exp=1", i, Vacio); else n_pass++;
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_glitch();
      test_stable_sequence();
      test_overflow();
      test_push_pop_full();
      test_random();
      test_reset_mid_qual();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/receptor_bus16.md
Name: receptor_bus16

Overview:
Read-side endpoint of the shared 16-bit tri-state bus that our three-state buffers drive. The block qualifies the bus with the driver's enable (Habilitador) and accepts a word only after it has held stable for a programmable number of cycles. Accepted words are queued in a small FIFO and presented to the consumer through a valid/ready handshake. It sits between the bus fabric and any register or datapath logic that consumes bus transfers.

Parameters:
ANCHO, 16, bus and data width in bits.
PROF, 4, FIFO depth in words; must be a power of 2, ≥2.
ESTABLE, 2, consecutive cycles the bus must hold the same value with Habilitador=1 before capture; legal range 2..15.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
Bus  input  ANCHO  shared tri-state bus, read side; synchronous to clk.
Habilitador  input  1  driver output-enable; 1 = bus is being driven.
Dato  output  ANCHO  head-of-FIFO word (first-word-fall-through).
Valido  output  1  Dato is valid (FIFO not empty).
Listo  input  1  consumer ready; pop on Valido&&Listo.
Lleno  output  1  FIFO holds PROF words.
Vacio  output  1  FIFO holds 0 words.
Cuenta  output  $clog2(PROF)+1  current word count, 0..PROF.
Desborde  output  1  sticky: a qualified word was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0, asynchronous): state=INACTIVO; ref register=0; stability counter=0; FIFO pointers=0; Dato=0, Valido=0, Vacio=1, Lleno=0, Cuenta=0, Desborde=0. FIFO contents are discarded. A reset in the middle of qualification or a transfer aborts it with no partial push.
- Capture FSM, evaluated at each rising edge:
  INACTIVO: if Habilitador=1, set ref<=Bus and cnt<=1, go to ESTABILIZANDO; otherwise stay.
  ESTABILIZANDO: if Habilitador=0, go to INACTIVO with no push. Else if Bus!=ref, set ref<=Bus and cnt<=1. Else cnt<=cnt+1; when cnt+1==ESTABLE, issue a push of ref and go to CAPTURADO.
  CAPTURADO: if Habilitador=0, go to INACTIVO. Else if Bus!=ref, set ref<=Bus and cnt<=1, go to ESTABILIZANDO (a new word). Else hold. No repeated push of the same stable value.
- Capture latency: with Habilitador=1 and a stable value sampled at edges k..k+ESTABLE-1, the push happens at edge k+ESTABLE-1. Valido=1 follows combinationally from the updated count after that edge.
- FIFO is circular, PROF entries, with ptr width $clog2(PROF) and natural wrap-around.
  - Dato=mem[rd_ptr].
  - Valido=!Vacio.
  - Pop occurs when Valido&&Listo at the edge.
  - Push when full with no pop in the same cycle: the word is dropped, Desborde<=1 and remains set until reset; Cuenta is unchanged.
  - Simultaneous push and pop when full: both are accepted; Cuenta stays PROF and Lleno stays 1.
  - Simultaneous push and pop when not empty: Cuenta is unchanged.
  - Push when empty: no bypass; Valido rises after the write edge.
  - Pop when empty: ignored, since Valido=0.
- Listo has no effect on the capture FSM; backpressure is expressed only through Lleno.
- Vacio=(Cuenta==0); Lleno=(Cuenta==PROF).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with Bus=16'hFFFF and Habilitador=1 -> all outputs at reset values. Release -> with ESTABLE=2, push 16'hFFFF one edge after the first qualifying sample; Dato=16'hFFFF, Valido=1, Cuenta=1.
- Glitch rejection: Bus increments every cycle while Habilitador toggles every cycle, 32 cycles starting at 16'h0000 -> no push; Vacio=1 throughout.
- Stable sequence: Habilitador=1, Bus holds 16'h1234 for 3 cycles, then 16'h5678 for 3 cycles, Listo=1 -> Dato/Valido present 16'h1234 then 16'h5678, each exactly once.
- Full/overflow: Listo=0; push 5 distinct words (16'h0001..16'h0005) with PROF=4 -> Lleno=1, Cuenta=4, Desborde=1. Then Listo=1 -> words 0001..0004 pop in order; 0005 is absent.
- Simultaneous push/pop at full: FIFO full, Listo=1 while a new word 16'hAAAA qualifies -> Cuenta stays 4, Desborde stays 0, and 16'hAAAA drains last.
- Reset mid-qualification: Habilitador=1 with Bus=16'hBEEF for 1 cycle, assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately; 16'hBEEF is never pushed.
